// File: rtl/dphy_hs_rx.sv
// D-PHY HS receive lane back end: DDR deserialiser, leader/sync detection and PPI byte outputs.
// Optional zero-run qualification before sync search is compiled in with `define HSRX_ZERO_CHECK_EN.
module dphy_hs_rx #(
    parameter logic [7:0]  SYNC_BYTE     = 8'h1D,
    parameter int unsigned MIN_ZERO_BITS = 6
) (
    input  logic       RxDDRClkHS,
    input  logic       RxRst,
    input  logic       RxByteClkHS,
    input  logic       HSRX_EN,
    input  logic       HS_Dp,
    output logic [2:0] RxState,
    output logic [7:0] RxDataHS,
    output logic [3:0] RxSyncPosition,
    output logic       RxActiveHS,
    output logic       RxSyncHS,
    output logic       RxValidHS
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ZERO    = 3'd1,
        SYNC    = 3'd2,
        RECEIVE = 3'd3
    } rxState_t;

    rxState_t   state;
    logic       b1Reg;
    logic [8:0] hist;
    logic       pairB1;
    logic       pairB2;
    logic       evenHit;
    logic       oddHit;
    logic       searchEn;
    logic [6:0] asmReg;
    logic [2:0] bitCnt;
    logic       unusedByteClk;

    assign unusedByteClk = RxByteClkHS;

    always_ff @(negedge RxDDRClkHS or posedge RxRst) begin
        if (RxRst) b1Reg <= 1'b0;
        else       b1Reg <= HS_Dp;
    end

    // hist[1:0] is the most recent pair {b1, b2}; the FSM consumes it one edge after capture
    always_ff @(posedge RxDDRClkHS or posedge RxRst) begin
        if (RxRst) hist <= '0;
        else       hist <= {hist[6:0], b1Reg, HS_Dp};
    end

    assign pairB1  = hist[1];
    assign pairB2  = hist[0];
    assign evenHit = (hist[7:0] == SYNC_BYTE);
    assign oddHit  = (hist[8:1] == SYNC_BYTE);

`ifdef HSRX_ZERO_CHECK_EN
    localparam int unsigned ZCW = $clog2(MIN_ZERO_BITS + 1) + 1;

    logic [ZCW-1:0] zeroCnt;
    logic [ZCW-1:0] zeroCntNext;
    logic           zeroDone;
    int unsigned    zeroSum;

    always_comb begin
        zeroSum = 0;
        if (pairB2)      zeroSum = 0;
        else if (pairB1) zeroSum = 1;
        else             zeroSum = 32'(zeroCnt) + 32'd2;
        if (zeroSum >= MIN_ZERO_BITS) zeroSum = MIN_ZERO_BITS;
    end

    assign zeroCntNext = ZCW'(zeroSum);
    assign zeroDone    = (state == ZERO) && (zeroSum >= MIN_ZERO_BITS);

    always_ff @(posedge RxDDRClkHS or posedge RxRst) begin
        if (RxRst)                          zeroCnt <= '0;
        else if (!HSRX_EN || state != ZERO) zeroCnt <= '0;
        else                                zeroCnt <= zeroCntNext;
    end

    // The pair that completes the zero run is also searched for sync
    assign searchEn = (state == SYNC) || zeroDone;
`else
    localparam int unsigned unusedMinZero = MIN_ZERO_BITS;

    assign searchEn = (state == SYNC);
`endif

    always_ff @(posedge RxDDRClkHS or posedge RxRst) begin
        if (RxRst) begin
            state          <= IDLE;
            RxDataHS       <= '0;
            RxSyncPosition <= '0;
            RxActiveHS     <= 1'b0;
            RxSyncHS       <= 1'b0;
            RxValidHS      <= 1'b0;
            asmReg         <= '0;
            bitCnt         <= '0;
        end else begin
            RxSyncHS  <= 1'b0;
            RxValidHS <= 1'b0;
            if (!HSRX_EN) begin
                state      <= IDLE;
                RxActiveHS <= 1'b0;
                asmReg     <= '0;
                bitCnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        asmReg <= '0;
                        bitCnt <= '0;
`ifdef HSRX_ZERO_CHECK_EN
                        state  <= ZERO;
`else
                        state  <= SYNC;
`endif
                    end
`ifdef HSRX_ZERO_CHECK_EN
                    ZERO: begin
                        if (zeroDone) state <= SYNC;
                    end
`endif
                    SYNC: state <= SYNC;
                    RECEIVE: begin
                        // Odd alignment keeps bitCnt odd: the byte closes on b1 and b2 is carried over
                        if (bitCnt == 3'd6) begin
                            RxDataHS  <= {asmReg[5:0], pairB1, pairB2};
                            RxValidHS <= 1'b1;
                            bitCnt    <= 3'd0;
                        end else if (bitCnt == 3'd7) begin
                            RxDataHS  <= {asmReg[6:0], pairB1};
                            RxValidHS <= 1'b1;
                            asmReg    <= {6'b0, pairB2};
                            bitCnt    <= 3'd1;
                        end else begin
                            asmReg <= {asmReg[4:0], pairB1, pairB2};
                            bitCnt <= bitCnt + 3'd2;
                        end
                    end
                    default: state <= IDLE;
                endcase

                if (searchEn && (evenHit || oddHit)) begin
                    state          <= RECEIVE;
                    RxActiveHS     <= 1'b1;
                    RxSyncHS       <= 1'b1;
                    RxSyncPosition <= {3'b000, oddHit};
                    asmReg         <= {6'b0, oddHit & pairB2};
                    bitCnt         <= oddHit ? 3'd1 : 3'd0;
                end
            end
        end
    end

    assign RxState = state;

endmodule

// File: tb/tb_dphy_hs_rx.sv
// Scoreboard bench for dphy_hs_rx: expected sync positions and bytes queued with stimulus, checked on output pulses.
module tb_dphy_hs_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byteClk = 1'b0;
    logic       en = 1'b0;
    logic       dp = 1'b0;
    logic [2:0] RxState;
    logic [7:0] RxDataHS;
    logic [3:0] RxSyncPosition;
    logic       RxActiveHS;
    logic       RxSyncHS;
    logic       RxValidHS;

    dphy_hs_rx #(.SYNC_BYTE(8'h1D), .MIN_ZERO_BITS(6)) dut (
        .RxDDRClkHS     (clk),
        .RxRst          (rst),
        .RxByteClkHS    (byteClk),
        .HSRX_EN        (en),
        .HS_Dp          (dp),
        .RxState        (RxState),
        .RxDataHS       (RxDataHS),
        .RxSyncPosition (RxSyncPosition),
        .RxActiveHS     (RxActiveHS),
        .RxSyncHS       (RxSyncHS),
        .RxValidHS      (RxValidHS)
    );

    always #5  clk = ~clk;
    always #20 byteClk = ~byteClk;

    int         nChecks = 0;
    int         nPass = 0;
    int         cyc = 0;
    int         lastValid = -100;
    logic [7:0] byteQ[$];
    logic [3:0] syncQ[$];
    bit         bitQ[$];
    logic [7:0] expByte;
    logic [3:0] expPos;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (RxValidHS) begin
                checkVal("byteExpected", 32'(byteQ.size() > 0), 32'd1);
                if (byteQ.size() > 0) begin
                    expByte = byteQ.pop_front();
                    checkVal("byte", 32'(RxDataHS), 32'(expByte));
                end
                checkVal("validInReceive", {28'd0, RxActiveHS, RxState}, {28'd0, 1'b1, 3'd3});
                if (cyc - lastValid < 8) checkVal("validPeriod", 32'(cyc - lastValid), 32'd4);
                lastValid = cyc;
            end
            if (RxSyncHS) begin
                checkVal("syncExpected", 32'(syncQ.size() > 0), 32'd1);
                if (syncQ.size() > 0) begin
                    expPos = syncQ.pop_front();
                    checkVal("syncPos", 32'(RxSyncPosition), 32'(expPos));
                end
                checkVal("syncActive", {28'd0, RxActiveHS, RxState}, {28'd0, 1'b1, 3'd3});
            end
        end
    end

    task automatic sendPair(input bit a, input bit b);
        @(posedge clk); #1 dp = a;
        @(negedge clk); #1 dp = b;
    endtask

    task automatic pushByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bitQ.push_back(v[i]);
    endtask

    task automatic flushBits();
        bit a;
        bit b;
        while (bitQ.size() > 0) begin
            a = bitQ.pop_front();
            b = (bitQ.size() > 0) ? bitQ.pop_front() : 1'b0;
            sendPair(a, b);
        end
    endtask

    task automatic enableNow();
        @(posedge clk); #1 en = 1'b1;
    endtask

    task automatic disableAfterStream();
        repeat (2) @(posedge clk);
        #1 en = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset with random line activity
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1 dp = 1'($urandom_range(0, 1));
            if (i % 4 == 3) begin
                @(negedge clk);
                checkVal("rstState", 32'(RxState), 32'd0);
                checkVal("rstData", 32'(RxDataHS), 32'd0);
                checkVal("rstFlags", {28'd0, RxSyncPosition == 4'd0, RxActiveHS, RxSyncHS, RxValidHS}, 32'h8);
            end
        end
        @(negedge clk); #1 rst = 1'b0; dp = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkVal("holdState", 32'(RxState), 32'd0);
        checkVal("holdOut", {20'd0, RxDataHS, RxActiveHS, RxSyncHS, RxValidHS, 1'b0}, 32'd0);

        // Nominal even alignment followed by an idle tail of zeros
        syncQ.push_back(4'd0);
        foreach (byteQ[i]) byteQ.delete(i);
        pushByte(8'h00); pushByte(8'h1D); pushByte(8'h1D);
        byteQ.push_back(8'h1D);
        pushByte(8'hAA); byteQ.push_back(8'hAA);
        pushByte(8'hBB); byteQ.push_back(8'hBB);
        pushByte(8'hCC); byteQ.push_back(8'hCC);
        pushByte(8'hDD); byteQ.push_back(8'hDD);
        pushByte(8'hEE); byteQ.push_back(8'hEE);
        for (int i = 0; i < 3; i++) begin
            pushByte(8'h00); byteQ.push_back(8'h00);
        end
        enableNow();
        flushBits();
        @(negedge clk);
        checkVal("nomActive", {29'd0, RxActiveHS, RxState == 3'd3, 1'b0}, 32'd6);
        disableAfterStream();
        checkVal("nomQueue", 32'(byteQ.size()), 32'd0);
        @(negedge clk);
        checkVal("nomIdle", {28'd0, RxActiveHS, RxState}, 32'd0);
        checkVal("nomHold", 32'(RxDataHS), 32'h00);

        // Odd alignment: one leading extra zero bit
        dp = 1'b0;
        repeat (3) @(posedge clk);
        syncQ.push_back(4'd1);
        bitQ.push_back(1'b0);
        pushByte(8'h00); pushByte(8'h1D); pushByte(8'h1D);
        byteQ.push_back(8'h1D);
        pushByte(8'hAA); byteQ.push_back(8'hAA);
        pushByte(8'hBB); byteQ.push_back(8'hBB);
        pushByte(8'hCC); byteQ.push_back(8'hCC);
        pushByte(8'hDD); byteQ.push_back(8'hDD);
        pushByte(8'hEE); byteQ.push_back(8'hEE);
        enableNow();
        flushBits();
        disableAfterStream();
        checkVal("oddQueue", 32'(byteQ.size()), 32'd0);
        checkVal("oddHold", 32'(RxDataHS), 32'hEE);

        // Mid-byte disable after three bits of AA
        dp = 1'b0;
        repeat (3) @(posedge clk);
        syncQ.push_back(4'd0);
        pushByte(8'h00); pushByte(8'h1D); pushByte(8'h1D);
        byteQ.push_back(8'h1D);
        bitQ.push_back(1'b1); bitQ.push_back(1'b0);
        enableNow();
        flushBits();
        @(posedge clk); #1 dp = 1'b1; en = 1'b0;
        @(negedge clk);
        checkVal("midBefore", 32'(RxState), 32'd3);
        @(negedge clk);
        checkVal("midState", 32'(RxState), 32'd0);
        checkVal("midActive", 32'(RxActiveHS), 32'd0);
        checkVal("midData", 32'(RxDataHS), 32'h1D);
        repeat (8) @(posedge clk);
        checkVal("midQueue", 32'(byteQ.size()), 32'd0);

        // Only three zeros ahead of the sync byte
        dp = 1'b1;
        repeat (4) @(posedge clk);
`ifndef HSRX_ZERO_CHECK_EN
        syncQ.push_back(4'd1);
`endif
        bitQ.push_back(1'b1);
        pushByte(8'h1D);
        bitQ.push_back(1'b1);
        enableNow();
        flushBits();
        repeat (2) @(posedge clk);
        #1;
`ifdef HSRX_ZERO_CHECK_EN
        checkVal("zeroState", 32'(RxState), 32'd1);
`else
        checkVal("zeroState", 32'(RxState), 32'd3);
`endif
        en = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkVal("zeroIdle", 32'(RxState), 32'd0);

        checkVal("syncQueue", 32'(syncQ.size()), 32'd0);
        checkVal("byteQueue", 32'(byteQ.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
